neuron_mac: RTL and testbench

- Multiply-accumulate neuron datapath sitting directly downstream of a per-neuron weight ROM (synchronous read, 1-cycle latency, `ren`/address/data interface).
- Consumes one activation per `in_valid` cycle and issues the matching weight read.
- Multiplies in signed fixed point and accumulates `NUM_WEIGHT` products, then adds bias, saturates and emits one neuron output.
- One instance per neuron; feeds the activation/next-layer input stage.

---
 rtl/fnn_pkg.sv | 37 +++
 rtl/neuron_sat_stage.sv | 61 ++++++
 rtl/neuron_mac.sv | 110 +++++++++++
 tb/tb_neuron_mac.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fnn_pkg.sv
// Shared types and helpers for the feed-forward neuron datapath.
//   DATA_WIDTH / FRAC_BITS : default signed fixed-point format (Q4.12)
//   data_t                 : one signed DATA_WIDTH quantity
//   token_t                : pipeline tag {valid, first, last}
//   sat_to_data            : clamp a wide signed value to a signed width
package fnn_pkg;

  localparam int unsigned DATA_WIDTH   = 16;
  localparam int unsigned FRAC_BITS    = 12;
  localparam int unsigned SAT_IN_WIDTH = 64;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } token_t;

  // Clamps val to [-2^(width-1), 2^(width-1)-1]; the caller keeps the low width bits.
  function automatic logic signed [SAT_IN_WIDTH-1:0] sat_to_data(
    input logic signed [SAT_IN_WIDTH-1:0] val,
    input int unsigned                    width
  );
    logic signed [SAT_IN_WIDTH-1:0] max_v;
    logic signed [SAT_IN_WIDTH-1:0] min_v;
    max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (val > max_v) begin
      return max_v;
    end else if (val < min_v) begin
      return min_v;
    end
    return val;
  endfunction

endpackage

// File: rtl/neuron_sat_stage.sv
// Output stage of the neuron: adds the bias (aligned to the product scale), rescales
// back to DATA_WIDTH fixed point with an arithmetic shift, saturates, optionally applies
// ReLU, and registers the result.
// Build option: define NEURON_RELU_EN to clamp negative results to zero (same latency).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : stage-3 token is the last of a vector; load a new output
//   acc        : full-precision signed accumulator
//   bias       : signed bias in DATA_WIDTH fixed point
//   out_valid  : one-cycle pulse with each new out_data
//   out_data   : saturated signed neuron output (holds between pulses)
module neuron_sat_stage
  import fnn_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FRAC_BITS  = 12,
  parameter int unsigned ACC_WIDTH  = 36
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [ACC_WIDTH-1:0]  acc,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  // One guard bit: acc plus the shifted bias cannot overflow this width.
  localparam int unsigned SumWidth = ACC_WIDTH + 1;

  logic signed [SumWidth-1:0]   bias_ext;
  logic signed [SumWidth-1:0]   sum;
  logic signed [SumWidth-1:0]   shifted;
  logic signed [DATA_WIDTH-1:0] result;

  always_comb begin
    bias_ext = SumWidth'($signed(bias)) <<< FRAC_BITS;
    sum      = SumWidth'($signed(acc)) + bias_ext;
    shifted  = sum >>> FRAC_BITS;
    result   = DATA_WIDTH'(sat_to_data(SAT_IN_WIDTH'(shifted), DATA_WIDTH));
`ifdef NEURON_RELU_EN
    if (result[DATA_WIDTH-1]) begin
      result = '0;
    end
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= en;
      if (en) begin
        out_data <= result;
      end
    end
  end

endmodule

// File: rtl/neuron_mac.sv
// Multiply-accumulate neuron fed by a synchronous weight ROM (1-cycle read latency).
// Each in_valid activation issues the matching weight read; products are summed over
// NUM_WEIGHT inputs, then bias-added, saturated and emitted 4 cycles after the last input.
// Build option: NEURON_RELU_EN (see neuron_sat_stage).
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid, in_data : activation stream, no backpressure
//   bias              : signed bias, held static
//   w_ren, w_radd     : weight ROM read enable / address
//   w_data            : weight ROM data, valid the cycle after w_ren
//   out_valid         : one-cycle pulse, out_data valid
//   out_data          : saturated signed neuron output
//   busy              : partial vector in flight or any stage holds a token
module neuron_mac
  import fnn_pkg::*;
#(
  parameter int unsigned NUM_WEIGHT = 10,
  parameter int unsigned ADDR_WIDTH = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1,
  parameter int unsigned DATA_WIDTH = fnn_pkg::DATA_WIDTH,
  parameter int unsigned FRAC_BITS  = fnn_pkg::FRAC_BITS,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(NUM_WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  w_ren,
  output logic [ADDR_WIDTH-1:0] w_radd,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(NUM_WEIGHT - 1);

  logic [ADDR_WIDTH-1:0]        cnt_q, cnt_d;
  token_t                       tok_in;
  token_t                       s1_q, s2_q;
  logic                         s3_valid_q, s3_last_q;
  logic signed [DATA_WIDTH-1:0] x_d1_q;
  logic signed [ProdWidth-1:0]  prod_q, prod_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;

  assign w_ren  = in_valid;
  assign w_radd = cnt_q;
  assign busy   = (cnt_q != '0) | s1_q.valid | s2_q.valid | s3_valid_q;

  always_comb begin
    tok_in.valid = in_valid;
    tok_in.first = (cnt_q == '0);
    tok_in.last  = (cnt_q == LastIdx);
    cnt_d        = cnt_q;
    if (in_valid) begin
      cnt_d = tok_in.last ? '0 : cnt_q + ADDR_WIDTH'(1);
    end
  end

  always_comb begin
    prod_d = (ProdWidth)'(x_d1_q) * (ProdWidth)'($signed(w_data));
    acc_d  = acc_q;
    if (s2_q.valid) begin
      // The first tag restarts the sum, so back-to-back vectors need no bubble.
      acc_d = (s2_q.first ? '0 : acc_q) + ACC_WIDTH'(prod_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      s3_valid_q <= 1'b0;
      s3_last_q  <= 1'b0;
      x_d1_q     <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      s1_q       <= tok_in;
      s2_q       <= s1_q;
      s3_valid_q <= s2_q.valid;
      s3_last_q  <= s2_q.last;
      if (in_valid) begin
        x_d1_q <= in_data;
      end
      if (s1_q.valid) begin
        prod_q <= prod_d;
      end
      acc_q <= acc_d;
    end
  end

  neuron_sat_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (s3_valid_q & s3_last_q),
    .acc      (acc_q),
    .bias     (bias),
    .out_valid(out_valid),
    .out_data (out_data)
  );

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with NUM_WEIGHT=30 and a behavioural synchronous weight ROM.
module tb_neuron_mac;
  import fnn_pkg::*;

  localparam int unsigned NW = 30;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  data_t         in_data = '0;
  data_t         bias = '0;
  data_t         w_data = '0;
  logic          w_ren;
  logic [AW-1:0] w_radd;
  logic          out_valid;
  data_t         out_data;
  logic          busy;

  data_t rom [NW];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    pulse_cyc[$];
  data_t pulse_dat[$];

  neuron_mac #(
    .NUM_WEIGHT(NW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .bias     (bias),
    .w_ren    (w_ren),
    .w_radd   (w_radd),
    .w_data   (w_data),
    .out_valid(out_valid),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (w_ren) w_data <= rom[w_radd];
  end

  always @(negedge clk) begin
    if (out_valid) begin
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(out_data);
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_rom(input data_t w);
    for (int i = 0; i < int'(NW); i++) rom[i] = w;
  endtask

  // Drives n consecutive in_valid cycles; leaves in_valid high at the end.
  task automatic send(input data_t x, input int n, output int last_cyc, inout int radd_err);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = x;
      if (w_radd !== AW'(i % int'(NW))) radd_err++;
      last_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic run_vector(input string tag, input data_t x, input data_t w, input data_t b,
                            input data_t exp);
    int last_cyc;
    int radd_err;
    radd_err = 0;
    last_cyc = 0;
    fill_rom(w);
    bias = b;
    pulse_cyc.delete();
    pulse_dat.delete();
    send(x, NW, last_cyc, radd_err);
    idle(1);
    check({tag, "_busy_tail"}, 16'(busy), 16'd1);
    idle(10);
    check({tag, "_radd_seq_err"}, 16'(radd_err), 16'd0);
    check({tag, "_busy_idle"}, 16'(busy), 16'd0);
    check({tag, "_npulse"}, 16'(pulse_cyc.size()), 16'd1);
    if (pulse_cyc.size() > 0) begin
      check({tag, "_data"}, pulse_dat[0], exp);
      check({tag, "_latency"}, 16'(pulse_cyc[0] - last_cyc), 16'd4);
    end
  endtask

  initial begin
    int last1;
    int last2;
    int rerr;
    data_t exp_neg;

    fill_rom(16'sh1000);
    // In reset with in_valid asserted: everything must stay cleared.
    in_valid = 1'b1;
    in_data  = 16'sh0080;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_w_radd", 16'(w_radd), 16'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(2);

    run_vector("basic", 16'sh0080, 16'sh1000, 16'sh0000, 16'sh0F00);
    run_vector("bias", 16'sh0080, 16'sh1000, 16'sh1000, 16'sh1F00);
    run_vector("sat_pos", 16'sh7FFF, 16'sh7FFF, 16'sh0000, 16'sh7FFF);
`ifdef NEURON_RELU_EN
    exp_neg = 16'sh0000;
`else
    exp_neg = 16'sh8000;
`endif
    run_vector("sat_neg", 16'sh8000, 16'sh7FFF, 16'sh0000, exp_neg);

    // Back-to-back vectors with no gap.
    fill_rom(16'sh1000);
    bias = '0;
    pulse_cyc.delete();
    pulse_dat.delete();
    rerr  = 0;
    last1 = 0;
    last2 = 0;
    send(16'sh0080, NW, last1, rerr);
    send(16'sh0100, NW, last2, rerr);
    idle(10);
    check("b2b_radd_seq_err", 16'(rerr), 16'd0);
    check("b2b_npulse", 16'(pulse_cyc.size()), 16'd2);
    if (pulse_cyc.size() == 2) begin
      check("b2b_data0", pulse_dat[0], 16'h0F00);
      check("b2b_data1", pulse_dat[1], 16'h1E00);
      check("b2b_spacing", 16'(pulse_cyc[1] - pulse_cyc[0]), 16'd30);
      check("b2b_latency0", 16'(pulse_cyc[0] - last1), 16'd4);
    end

    // Reset mid-vector discards the partial sum.
    pulse_cyc.delete();
    pulse_dat.delete();
    rerr  = 0;
    send(16'sh0080, 12, last1, rerr);
    check("mid_busy", 16'(busy), 16'd1);
    check("mid_radd_seq_err", 16'(rerr), 16'd0);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'sh7FFF;
    @(posedge clk);
    #1;
    check("mid_rst_radd", 16'(w_radd), 16'd0);
    check("mid_rst_busy", 16'(busy), 16'd0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(6);
    check("mid_rst_no_pulse", 16'(pulse_cyc.size()), 16'd0);
    run_vector("after_rst", 16'sh0080, 16'sh1000, 16'sh0000, 16'sh0F00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
